// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants, types and helpers for the ALU issue controller and its
// load scoreboard.
package alu_issue_ctrl_pkg;

   localparam int cXLEN          = 32;
   localparam int cRegSelBitW    = 5;
   localparam int cRegPipeDepth  = 3;
   localparam int cBranchTimeout = 4;
   localparam int cNumRegs       = 1 << cRegSelBitW;
   localparam int cTimerW        = (cBranchTimeout > 2) ? $clog2(cBranchTimeout) : 1;

   typedef logic [cRegSelBitW-1:0] tRegAddr;

   typedef enum logic [1:0] {
      eRun    = 2'd0,
      eBrWait = 2'd1,
      eFlush  = 2'd2
   } tIssueState;

   typedef struct packed {
      logic    valid;
      tRegAddr rs1Addr;
      tRegAddr rs2Addr;
      logic    useRs1;
      logic    useRs2;
      tRegAddr rdAddr;
      logic    writesRd;
      logic    isLoad;
      logic    isBranch;
   } tIssueReq;

   // x0 is hardwired, so a read of it can never depend on an older writer.
   function automatic logic srcMatch(input logic useSrc, input tRegAddr src, input tRegAddr rd);
      return useSrc && (src != tRegAddr'(0)) && (src == rd);
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Decode/ALU-side handshake bundle of the issue controller.
interface alu_issue_ctrl_if;
   import alu_issue_ctrl_pkg::*;

   logic             iIssueValid;
   tRegAddr          iRs1Addr;
   tRegAddr          iRs2Addr;
   logic             iUseRs1;
   logic             iUseRs2;
   tRegAddr          iRdAddr;
   logic             iWritesRd;
   logic             iIsLoad;
   logic             iIsBranch;
   logic             iLoadDoneValid;
   tRegAddr          iLoadDoneAddr;
   logic             iBranchValid;
   logic             iBranchTaken;
   logic             oIssueReady;
   logic             oIssueFire;
   logic             oFlush;
   logic             oBranchErr;
   logic [cXLEN-1:0] oStallCnt;

   modport master (
      output iIssueValid, iRs1Addr, iRs2Addr, iUseRs1, iUseRs2, iRdAddr,
             iWritesRd, iIsLoad, iIsBranch, iLoadDoneValid, iLoadDoneAddr,
             iBranchValid, iBranchTaken,
      input  oIssueReady, oIssueFire, oFlush, oBranchErr, oStallCnt
   );

   modport slave (
      input  iIssueValid, iRs1Addr, iRs2Addr, iUseRs1, iUseRs2, iRdAddr,
             iWritesRd, iIsLoad, iIsBranch, iLoadDoneValid, iLoadDoneAddr,
             iBranchValid, iBranchTaken,
      output oIssueReady, oIssueFire, oFlush, oBranchErr, oStallCnt
   );

endinterface

// File: rtl/alu_issue_ctrl_load_scoreboard.sv
// Busy bit per architectural register for loads still waiting on memory;
// a set and a clear of the same register in one cycle leaves it busy.
module alu_issue_ctrl_load_scoreboard
   import alu_issue_ctrl_pkg::*;
(
   input  logic    iClk,
   input  logic    iRst,
   input  logic    iSetEn,
   input  tRegAddr iSetAddr,
   input  logic    iClrEn,
   input  tRegAddr iClrAddr,
   input  tRegAddr iRdAddrA,
   output logic    oBusyA,
   input  tRegAddr iRdAddrB,
   output logic    oBusyB
);

   localparam logic [cNumRegs-1:0] cOneHot0 = {{(cNumRegs-1){1'b0}}, 1'b1};

   logic [cNumRegs-1:0] busy_r;
   logic [cNumRegs-1:0] setMask_s;
   logic [cNumRegs-1:0] clrMask_s;
   logic [cNumRegs-1:0] busyNext_s;

   // Next busy vector: clear first, then set, so set wins; x0 is never marked.
   always_comb begin
      setMask_s  = (iSetEn && (iSetAddr != tRegAddr'(0))) ? (cOneHot0 << iSetAddr)
                                                          : {cNumRegs{1'b0}};
      clrMask_s  = iClrEn ? (cOneHot0 << iClrAddr) : {cNumRegs{1'b0}};
      busyNext_s = (busy_r & ~clrMask_s) | setMask_s;
   end

   // Busy bit storage.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         busy_r <= {cNumRegs{1'b0}};
      end else begin
         busy_r <= busyNext_s;
      end
   end

   assign oBusyA = busy_r[iRdAddrA];
   assign oBusyB = busy_r[iRdAddrB];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller between decode and the 2-cycle ALU: RAW hazard stalls,
// branch serialisation with flush/timeout, and a saturating stall counter.
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
(
   input logic             iClk,
   input logic             iRst,
   alu_issue_ctrl_if.slave bus
);

   tIssueReq               req_s;
   tIssueState             state_r;
   tIssueState             stateNext_s;
   logic [cTimerW-1:0]     brTimer_r;
   logic [cTimerW-1:0]     brTimerNext_s;
   logic                   brTimeout_s;
   logic                   flush_r;
   logic                   branchErr_r;
   logic [cXLEN-1:0]       stallCnt_r;
   logic [cRegPipeDepth-1:1] pipeVld_r;
   tRegAddr                pipeRd_r [1:cRegPipeDepth-1];
   logic                   pipeHazard_s;
   logic                   busyRs1_s;
   logic                   busyRs2_s;
   logic                   hazard_s;
   logic                   ready_s;
   logic                   fire_s;
   logic                   regOpFire_s;
   logic                   loadFire_s;

   assign req_s = '{
      valid:    bus.iIssueValid,
      rs1Addr:  bus.iRs1Addr,
      rs2Addr:  bus.iRs2Addr,
      useRs1:   bus.iUseRs1,
      useRs2:   bus.iUseRs2,
      rdAddr:   bus.iRdAddr,
      writesRd: bus.iWritesRd,
      isLoad:   bus.iIsLoad,
      isBranch: bus.iIsBranch
   };

   alu_issue_ctrl_load_scoreboard uSb (
      .iClk     (iClk),
      .iRst     (iRst),
      .iSetEn   (loadFire_s),
      .iSetAddr (req_s.rdAddr),
      .iClrEn   (bus.iLoadDoneValid),
      .iClrAddr (bus.iLoadDoneAddr),
      .iRdAddrA (req_s.rs1Addr),
      .oBusyA   (busyRs1_s),
      .iRdAddrB (req_s.rs2Addr),
      .oBusyB   (busyRs2_s)
   );

   // Stage 0 of the reg-op pipe is the issuing slot; stages 1.. are the ALU
   // cycles after it. The regfile write of the last stage forwards to reads.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         pipeVld_r <= {(cRegPipeDepth-1){1'b0}};
         for (int i = 1; i < cRegPipeDepth; i++) begin
            pipeRd_r[i] <= tRegAddr'(0);
         end
      end else begin
         pipeVld_r[1] <= regOpFire_s;
         pipeRd_r[1]  <= req_s.rdAddr;
         for (int i = 2; i < cRegPipeDepth; i++) begin
            pipeVld_r[i] <= pipeVld_r[i-1];
            pipeRd_r[i]  <= pipeRd_r[i-1];
         end
      end
   end

   // RAW hazard against in-flight reg-ops and outstanding loads.
   always_comb begin
      pipeHazard_s = 1'b0;
      for (int i = 1; i < cRegPipeDepth; i++) begin
         pipeHazard_s = pipeHazard_s |
                        (pipeVld_r[i] && (srcMatch(req_s.useRs1, req_s.rs1Addr, pipeRd_r[i]) ||
                                          srcMatch(req_s.useRs2, req_s.rs2Addr, pipeRd_r[i])));
      end
      hazard_s = pipeHazard_s ||
                 (req_s.useRs1 && (req_s.rs1Addr != tRegAddr'(0)) && busyRs1_s) ||
                 (req_s.useRs2 && (req_s.rs2Addr != tRegAddr'(0)) && busyRs2_s);
   end

   // FSM state, branch timer, flush pulse and sticky branch error.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_r     <= eRun;
         brTimer_r   <= {cTimerW{1'b0}};
         flush_r     <= 1'b0;
         branchErr_r <= 1'b0;
      end else begin
         state_r     <= stateNext_s;
         brTimer_r   <= brTimerNext_s;
         flush_r     <= (stateNext_s == eFlush);
         branchErr_r <= branchErr_r | brTimeout_s;
      end
   end

   // FSM next state; branch results outside BR_WAIT are ignored.
   always_comb begin
      stateNext_s   = state_r;
      brTimerNext_s = brTimer_r;
      brTimeout_s   = 1'b0;
      case (state_r)
         eRun: begin
            if (fire_s && req_s.isBranch) begin
               stateNext_s   = eBrWait;
               brTimerNext_s = {cTimerW{1'b0}};
            end else begin
               stateNext_s   = eRun;
            end
         end
         eBrWait: begin
            if (bus.iBranchValid) begin
               stateNext_s = bus.iBranchTaken ? eFlush : eRun;
            end else if (brTimer_r == cTimerW'(cBranchTimeout - 1)) begin
               stateNext_s = eRun;
               brTimeout_s = 1'b1;
            end else begin
               brTimerNext_s = brTimer_r + cTimerW'(1);
            end
         end
         eFlush:  stateNext_s = eRun;
         default: stateNext_s = eRun;
      endcase
   end

   // FSM outputs: issue gate and fire qualifiers.
   always_comb begin
      case (state_r)
         eRun:    ready_s = !hazard_s && !iRst;
         eBrWait: ready_s = 1'b0;
         eFlush:  ready_s = 1'b0;
         default: ready_s = 1'b0;
      endcase
      fire_s      = req_s.valid && ready_s;
      regOpFire_s = fire_s && req_s.writesRd && !req_s.isLoad;
      loadFire_s  = fire_s && req_s.isLoad;
   end

   // Saturating count of cycles decode was held off.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         stallCnt_r <= {cXLEN{1'b0}};
      end else if (req_s.valid && !ready_s && !(&stallCnt_r)) begin
         stallCnt_r <= stallCnt_r + cXLEN'(1);
      end else begin
         stallCnt_r <= stallCnt_r;
      end
   end

   assign bus.oIssueReady = ready_s;
   assign bus.oIssueFire  = fire_s;
   assign bus.oFlush      = flush_r;
   assign bus.oBranchErr  = branchErr_r;
   assign bus.oStallCnt   = stallCnt_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed plus random stimulus for alu_issue_ctrl, checked every cycle
// against a cycle-numbered reference model of the issue rules.
module tb_alu_issue_ctrl;
   import alu_issue_ctrl_pkg::*;

   logic iClk = 1'b0;
   logic iRst;
   always #5 iClk = ~iClk;

   alu_issue_ctrl_if bus ();
   alu_issue_ctrl dut (.iClk(iClk), .iRst(iRst), .bus(bus));

   int checks   = 0;
   int failures = 0;

   // Reference model: register readable-from cycle, load busy flags, branch wait.
   int     cyc = 0;
   int     regFreeAt [cNumRegs];
   bit     loadBusy  [cNumRegs];
   bit     brPending;
   bit     flushNow;
   bit     errSticky;
   int     brWaited;
   longint stallCnt;
   logic   obsReady;
   logic   obsFire;
   logic   obsFlush;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   function automatic bit srcBusy(input bit useSrc, input int a);
      return useSrc && (a != 0) && ((cyc < regFreeAt[a]) || loadBusy[a]);
   endfunction

   task automatic modelReset();
      for (int i = 0; i < cNumRegs; i++) begin
         regFreeAt[i] = 0;
         loadBusy[i]  = 1'b0;
      end
      brPending = 1'b0;
      flushNow  = 1'b0;
      errSticky = 1'b0;
      brWaited  = 0;
      stallCnt  = 0;
   endtask

   task automatic setReq(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit wr, input bit ld, input bit br);
      bus.iIssueValid = v;
      bus.iRs1Addr    = cRegSelBitW'(rs1);
      bus.iUseRs1     = u1;
      bus.iRs2Addr    = cRegSelBitW'(rs2);
      bus.iUseRs2     = u2;
      bus.iRdAddr     = cRegSelBitW'(rd);
      bus.iWritesRd   = wr;
      bus.iIsLoad     = ld;
      bus.iIsBranch   = br;
   endtask

   task automatic setAux(input bit ldv, input int lda, input bit bv, input bit bt);
      bus.iLoadDoneValid = ldv;
      bus.iLoadDoneAddr  = cRegSelBitW'(lda);
      bus.iBranchValid   = bv;
      bus.iBranchTaken   = bt;
   endtask

   // One clock: check outputs at the falling edge, then advance the model.
   task automatic cycle();
      bit expReady;
      bit expFire;
      bit nextFlush;
      int rd;
      @(negedge iClk);
      expReady = !iRst && !brPending && !flushNow &&
                 !srcBusy(bus.iUseRs1, int'(bus.iRs1Addr)) &&
                 !srcBusy(bus.iUseRs2, int'(bus.iRs2Addr));
      expFire  = bus.iIssueValid && expReady;
      obsReady = bus.oIssueReady;
      obsFire  = bus.oIssueFire;
      obsFlush = bus.oFlush;
      chk("ready",    32'(obsReady),       32'(expReady));
      chk("fire",     32'(obsFire),        32'(expFire));
      chk("flush",    32'(obsFlush),       32'(flushNow));
      chk("brErr",    32'(bus.oBranchErr), 32'(errSticky));
      chk("stallCnt", bus.oStallCnt,       stallCnt[31:0]);
      @(posedge iClk);
      if (iRst) begin
         modelReset();
      end else begin
         if (bus.iIssueValid && !expReady && stallCnt < 64'hFFFF_FFFF) stallCnt++;
         rd = int'(bus.iRdAddr);
         if (expFire && bus.iWritesRd && !bus.iIsLoad) regFreeAt[rd] = cyc + cRegPipeDepth;
         if (bus.iLoadDoneValid) loadBusy[int'(bus.iLoadDoneAddr)] = 1'b0;
         if (expFire && bus.iIsLoad && rd != 0) loadBusy[rd] = 1'b1;
         nextFlush = 1'b0;
         if (brPending) begin
            if (bus.iBranchValid) begin
               brPending = 1'b0;
               nextFlush = bus.iBranchTaken;
            end else begin
               brWaited++;
               if (brWaited == cBranchTimeout) begin
                  errSticky = 1'b1;
                  brPending = 1'b0;
               end
            end
         end
         if (expFire && bus.iIsBranch) begin
            brPending = 1'b1;
            brWaited  = 0;
         end
         flushNow = nextFlush;
      end
      cyc++;
      #1;
   endtask

   initial begin
      iRst = 1'b1;
      setReq(1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b0, 1'b0);
      setAux(1'b0, 0, 1'b0, 1'b0);
      modelReset();
      repeat (2) @(posedge iClk);
      #1;
      cycle();
      chk("reset_ready", 32'(obsReady), 32'd0);
      iRst = 1'b0;

      // Independent back-to-back ops
      setReq(1'b1, 2, 1'b1, 3, 1'b1, 1, 1'b1, 1'b0, 1'b0); cycle();
      chk("t1_ready_a", 32'(obsReady), 32'd1);
      setReq(1'b1, 5, 1'b1, 6, 1'b1, 4, 1'b1, 1'b0, 1'b0); cycle();
      chk("t1_ready_b", 32'(obsReady), 32'd1);
      chk("t1_stall", bus.oStallCnt, 32'd0);

      // RAW on a reg-op result
      setReq(1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1, 1'b0, 1'b0); cycle();
      setReq(1'b1, 5, 1'b1, 0, 1'b0, 8, 1'b1, 1'b0, 1'b0);
      cycle(); chk("t2_c1", 32'(obsReady), 32'd0);
      cycle(); chk("t2_c2", 32'(obsReady), 32'd0);
      cycle(); chk("t2_c3_fire", 32'(obsFire), 32'd1);
      chk("t2_stall", bus.oStallCnt, 32'd2);
      setReq(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0); repeat (3) cycle();

      // Load hazard, completion at cycle 6, no same-cycle bypass
      setReq(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 1'b1, 1'b0); cycle();
      setReq(1'b1, 0, 1'b0, 7, 1'b1, 9, 1'b1, 1'b0, 1'b0); repeat (5) cycle();
      chk("t3_c5", 32'(obsReady), 32'd0);
      setAux(1'b1, 7, 1'b0, 1'b0); cycle();
      chk("t3_c6_nobypass", 32'(obsReady), 32'd0);
      setAux(1'b0, 0, 1'b0, 1'b0); cycle();
      chk("t3_c7_fire", 32'(obsFire), 32'd1);
      chk("t3_stall", bus.oStallCnt, 32'd8);
      setReq(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 1'b1, 1'b0); setAux(1'b1, 7, 1'b0, 1'b0); cycle();
      setAux(1'b0, 0, 1'b0, 1'b0); setReq(1'b1, 7, 1'b1, 0, 1'b0, 10, 1'b1, 1'b0, 1'b0); cycle();
      chk("t3_setwins", 32'(obsReady), 32'd0);
      setReq(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0); setAux(1'b1, 7, 1'b0, 1'b0); cycle();
      setAux(1'b0, 0, 1'b0, 1'b0); setReq(1'b1, 7, 1'b1, 0, 1'b0, 10, 1'b1, 1'b0, 1'b0); cycle();
      chk("t3_cleared", 32'(obsReady), 32'd1);

      // Register x0
      setReq(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0); cycle();
      setReq(1'b1, 0, 1'b1, 0, 1'b1, 11, 1'b1, 1'b0, 1'b0); cycle();
      chk("t4_x0", 32'(obsReady), 32'd1);
      setReq(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b1, 1'b0); cycle();
      setReq(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0); cycle();
      chk("t4_busy0", 32'(dut.uSb.busy_r[0]), 32'd0);

      // Branch taken
      setReq(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1); cycle();
      chk("t5_brfire", 32'(obsFire), 32'd1);
      setReq(1'b1, 2, 1'b1, 0, 1'b0, 12, 1'b1, 1'b0, 1'b0); cycle();
      chk("t5_wait", 32'(obsReady), 32'd0);
      setAux(1'b0, 0, 1'b1, 1'b1); cycle();
      setAux(1'b0, 0, 1'b0, 1'b0); cycle();
      chk("t5_flush", 32'(obsFlush), 32'd1);
      chk("t5_flush_block", 32'(obsReady), 32'd0);
      cycle();
      chk("t5_flush_done", 32'(obsFlush), 32'd0);
      chk("t5_resume", 32'(obsFire), 32'd1);

      // Branch not taken
      setReq(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1); cycle();
      setReq(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0); cycle();
      setAux(1'b0, 0, 1'b1, 1'b0); cycle();
      setAux(1'b0, 0, 1'b0, 1'b0); setReq(1'b1, 2, 1'b1, 0, 1'b0, 12, 1'b1, 1'b0, 1'b0); cycle();
      chk("t5_nt_resume", 32'(obsFire), 32'd1);
      chk("t5_nt_noflush", 32'(obsFlush), 32'd0);
      setReq(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0); setAux(1'b0, 0, 1'b1, 1'b1); cycle();
      setAux(1'b0, 0, 1'b0, 1'b0); cycle();
      chk("t5_bv_ignored", 32'(obsFlush), 32'd0);

      // Branch timeout
      setReq(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1); cycle();
      setReq(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0); repeat (3) cycle();
      chk("t6_err_early", 32'(bus.oBranchErr), 32'd0);
      cycle();
      chk("t6_err", 32'(bus.oBranchErr), 32'd1);
      setReq(1'b1, 2, 1'b1, 0, 1'b0, 13, 1'b1, 1'b0, 1'b0); cycle();
      chk("t6_resume", 32'(obsFire), 32'd1);
      chk("t6_sticky", 32'(bus.oBranchErr), 32'd1);

      // Reset in BR_WAIT with a load outstanding
      setReq(1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b1, 1'b1, 1'b0); cycle();
      setReq(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1); cycle();
      setReq(1'b1, 9, 1'b1, 0, 1'b0, 14, 1'b1, 1'b0, 1'b0); cycle();
      iRst = 1'b1; cycle(); iRst = 1'b0;
      chk("t6_rst_err", 32'(bus.oBranchErr), 32'd0);
      chk("t6_rst_stall", bus.oStallCnt, 32'd0);
      cycle();
      chk("t6_rst_free", 32'(obsReady), 32'd1);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         iRst = ($urandom_range(0, 63) == 0);
         setReq(($urandom_range(0, 3) != 0),
                int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
         setAux($urandom_range(0, 2) == 0, int'($urandom_range(0, 7)),
                $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
         cycle();
      end
      iRst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue controller between decode and the 2-cycle ALU.
- Gates each decoded instruction into the ALU and stalls decode on RAW hazards against in-flight register-op results and outstanding loads.
- Serialises branches: no issue until the branch resolves. Pulses a flush to fetch/decode on a taken branch.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- cXLEN, 32, data/counter width.
- cRegSelBitW, 5, register address width.
- cRegPipeDepth, 3, cycles a register-op destination stays hazardous after issue (2 ALU stages + 1 regfile write).
- cBranchTimeout, 4, max cycles in BR_WAIT before error recovery.

Ports:
- iClk  in  1  clock
- iRst  in  1  synchronous active-high reset
- iIssueValid  in  1  decode presents an instruction
- iRs1Addr  in  cRegSelBitW  source 1 address
- iRs2Addr  in  cRegSelBitW  source 2 address
- iUseRs1  in  1  instruction reads rs1
- iUseRs2  in  1  instruction reads rs2
- iRdAddr  in  cRegSelBitW  destination address
- iWritesRd  in  1  register-op result written to rd
- iIsLoad  in  1  instruction is a load (rd written by memory)
- iIsBranch  in  1  branch/jal/jalr
- iLoadDoneValid  in  1  memory load writeback this cycle
- iLoadDoneAddr  in  cRegSelBitW  register written by that load
- iBranchValid  in  1  ALU branch result valid
- iBranchTaken  in  1  ALU branch taken
- oIssueReady  out  1  controller accepts the instruction this cycle
- oIssueFire  out  1  iIssueValid & oIssueReady; ALU dv qualifier
- oFlush  out  1  one-cycle flush of fetch/decode
- oBranchErr  out  1  sticky: branch never resolved
- oStallCnt  out  cXLEN  saturating count of stalled cycles

Behaviour:
- Reset (iRst=1 at clock edge) clears the following, regardless of other inputs, including a reset landing mid-branch or mid-load:
  - Reg-op pipe, load scoreboard and state → RUN.
  - oFlush=0, oBranchErr=0, oStallCnt=0.
  - oIssueReady is forced 0 while iRst=1.
- Reg-op pipe: shift register of cRegPipeDepth entries {valid, rd}.
  - Entry 0 loads {oIssueFire & iWritesRd & ~iIsLoad, iRdAddr} each cycle; the remaining entries shift.
- Load scoreboard: 2^cRegSelBitW busy bits.
  - Set bit iRdAddr on oIssueFire & iIsLoad.
  - Clear bit iLoadDoneAddr on iLoadDoneValid.
  - Same address set and cleared in the same cycle: set wins.
  - Bit 0 is never set.
- Hazard (combinational): for each used source with address ≠ 0, hazard if the address equals the rd of any valid pipe entry, or its scoreboard bit is set.
  - No bypass: a load completing in the same cycle still stalls.
- oIssueReady = (state==RUN) & ~hazard & ~iRst. oIssueFire is combinational.
- FSM:
  - RUN: oIssueFire & iIsBranch → BR_WAIT, timer cleared.
  - BR_WAIT: issue blocked.
    - iBranchValid & iBranchTaken → FLUSH.
    - iBranchValid & ~iBranchTaken → RUN.
    - Timer reaches cBranchTimeout-1 without iBranchValid → set oBranchErr, → RUN.
  - FLUSH: oFlush=1 for exactly this one cycle (registered), issue blocked → RUN.
- iBranchValid outside BR_WAIT is ignored.
- Stall counter: increments when iIssueValid & ~oIssueReady & ~iRst; holds at all-ones.
- Latency: issue is zero-cycle when no hazard. The earliest dependent reg-op issues cRegPipeDepth cycles after the producer.

Decomposition:
- Add to corePckg:
  - tIssueState enum {eRun, eBrWait, eFlush}.
  - cRegPipeDepth and cBranchTimeout constants.
  - tIssueReq struct bundling the decode-side inputs.
- Natural sub-module: load_scoreboard (busy bits, set/clear, two read ports).

Test Plan:
1. Back-to-back independent ops (rd=1, rs=2,3; then rd=4, rs=5,6) → oIssueReady=1 both cycles, oStallCnt stays 0.
2. RAW on reg-op: issue rd=5, then rs1=5 held valid → oIssueReady=0 for 2 cycles, fires on the 3rd cycle after the producer; oStallCnt=2.
3. Load hazard: load rd=7, dependent rs2=7; iLoadDoneValid addr=7 at cycle 6 → stall through cycle 6, issue at cycle 7; same-cycle load rd=7 plus done=7 leaves the bit set.
4. Source x0: rd=0 op then rs1=0 → no stall; load rd=0 never marks busy.
5. Branch taken: issue branch, iBranchValid=1, iBranchTaken=1 two cycles later → oFlush=1 for one cycle, then RUN; not taken → no flush, issue resumes the next cycle.
6. Branch timeout and reset: no iBranchValid for 4 cycles → oBranchErr=1 sticky, RUN resumes; iRst mid BR_WAIT with busy bits set → all cleared, oBranchErr=0, oStallCnt=0.
